// File: rtl/sha2_msg_schedule.sv
// SHA-2 message schedule expander: streams W[0..ROUNDS-1] from 16 message
// words through a 16-word sliding window, for SHA-256 (32) or SHA-512 (64).
module sha2_msg_schedule #(
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  output logic              w_valid,
  input  logic              w_ready,
  output logic [WORD_W-1:0] w_out,
  output logic [6:0]        w_idx,
  output logic              w_last
);

  localparam int ROUNDS = (WORD_W == 32) ? 64 : 80;
  localparam int S0A = (WORD_W == 32) ? 7  : 1;
  localparam int S0B = (WORD_W == 32) ? 18 : 8;
  localparam int S0C = (WORD_W == 32) ? 3  : 7;
  localparam int S1A = (WORD_W == 32) ? 17 : 19;
  localparam int S1B = (WORD_W == 32) ? 19 : 61;
  localparam int S1C = (WORD_W == 32) ? 10 : 6;

  if (WORD_W != 32 && WORD_W != 64) begin : g_bad_width
    $error("sha2_msg_schedule: WORD_W must be 32 or 64");
  end

  typedef enum logic {LOAD, EXPAND} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [WORD_W-1:0] win [16];
  logic [6:0]        t;
  logic              slot_free;
  logic              adv;
  logic              last_t;
  logic [WORD_W-1:0] s0;
  logic [WORD_W-1:0] s1;
  logic [WORD_W-1:0] w_new;
  logic [WORD_W-1:0] nxt_word;

  function automatic logic [WORD_W-1:0] rotr(
    input logic [WORD_W-1:0] x,
    input int                n
  );
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // win[0] is the newest word W[t-1], win[15] the oldest W[t-16]
  always_comb begin
    s0    = rotr(win[14], S0A) ^ rotr(win[14], S0B) ^ (win[14] >> S0C);
    s1    = rotr(win[1], S1A) ^ rotr(win[1], S1B) ^ (win[1] >> S1C);
    w_new = s1 + win[6] + s0 + win[15];
  end

  always_comb begin
    slot_free = !w_valid | w_ready;
    last_t    = (t == 7'(ROUNDS - 1));
    nxt_word  = (state == LOAD) ? in_word : w_new;
    adv       = !flush & slot_free
              & ((state == EXPAND) | in_valid);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= LOAD;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = LOAD;
    end else if (adv) begin
      unique case (state)
        LOAD:   if (t == 7'd15) state_nxt = EXPAND;
        EXPAND: if (last_t)     state_nxt = LOAD;
        default: state_nxt = LOAD;
      endcase
    end
  end

  always_comb begin
    in_ready = (state == LOAD) & slot_free & !flush;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      w_valid <= 1'b0;
      w_out   <= '0;
      w_idx   <= '0;
      w_last  <= 1'b0;
      t       <= '0;
      for (int i = 0; i < 16; i++) win[i] <= '0;
    end else if (flush) begin
      w_valid <= 1'b0;
      w_last  <= 1'b0;
      t       <= '0;
    end else if (adv) begin
      w_valid <= 1'b1;
      w_out   <= nxt_word;
      w_idx   <= t;
      w_last  <= last_t;
      t       <= last_t ? 7'd0 : t + 7'd1;
      win[0]  <= nxt_word;
      for (int i = 1; i < 16; i++) win[i] <= win[i-1];
    end else if (slot_free) begin
      w_valid <= 1'b0;
      w_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sha2_msg_schedule.sv
// Randomised bench for sha2_msg_schedule (32- and 64-bit instances) against
// an array-based schedule model with a queue scoreboard.
module tb_sha2_msg_schedule;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        flush32 = 0, in_valid32 = 0, w_ready32 = 1;
  logic        in_ready32, w_valid32, w_last32;
  logic [31:0] in_word32 = '0, w_out32;
  logic [6:0]  w_idx32;

  logic        flush64 = 0, in_valid64 = 0, w_ready64 = 1;
  logic        in_ready64, w_valid64, w_last64;
  logic [63:0] in_word64 = '0, w_out64;
  logic [6:0]  w_idx64;

  sha2_msg_schedule #(.WORD_W(32)) dut32 (
    .clk(clk), .rst(rst), .flush(flush32),
    .in_valid(in_valid32), .in_ready(in_ready32),
    .in_word(in_word32), .w_valid(w_valid32),
    .w_ready(w_ready32), .w_out(w_out32),
    .w_idx(w_idx32), .w_last(w_last32)
  );

  sha2_msg_schedule #(.WORD_W(64)) dut64 (
    .clk(clk), .rst(rst), .flush(flush64),
    .in_valid(in_valid64), .in_ready(in_ready64),
    .in_word(in_word64), .w_valid(w_valid64),
    .w_ready(w_ready64), .w_out(w_out64),
    .w_idx(w_idx64), .w_last(w_last64)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] w;
    int          idx;
  } ent_t;

  ent_t exp32[$];
  ent_t exp64[$];
  int   xcyc32[$];
  int   xcyc64[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  bit   rnd32 = 0;
  bit   rnd64 = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [63:0] rotr(input logic [63:0] x, input int n,
                                       input int w);
    logic [63:0] m;
    m = (w == 64) ? '1 : 64'hFFFF_FFFF;
    x = x & m;
    return ((x >> n) | (x << (w - n))) & m;
  endfunction

  function automatic logic [63:0] sig0(input logic [63:0] x, input int w);
    if (w == 32) return rotr(x, 7, w) ^ rotr(x, 18, w) ^ (x >> 3);
    return rotr(x, 1, w) ^ rotr(x, 8, w) ^ (x >> 7);
  endfunction

  function automatic logic [63:0] sig1(input logic [63:0] x, input int w);
    if (w == 32) return rotr(x, 17, w) ^ rotr(x, 19, w) ^ (x >> 10);
    return rotr(x, 19, w) ^ rotr(x, 61, w) ^ (x >> 6);
  endfunction

  function automatic void sched(input int w, input logic [63:0] m[16],
                                output logic [63:0] s[80]);
    logic [63:0] mask;
    int          n;
    mask = (w == 64) ? '1 : 64'hFFFF_FFFF;
    n = (w == 32) ? 64 : 80;
    for (int i = 0; i < 80; i++) s[i] = '0;
    for (int i = 0; i < 16; i++) s[i] = m[i] & mask;
    for (int i = 16; i < n; i++)
      s[i] = (sig1(s[i-2], w) + s[i-7] + sig0(s[i-15], w) + s[i-16]) & mask;
  endfunction

  function automatic void make_abc(input int w, output logic [63:0] m[16]);
    for (int i = 0; i < 16; i++) m[i] = '0;
    m[0]  = (w == 32) ? 64'h6162_6380 : 64'h6162_6380_0000_0000;
    m[15] = 64'h18;
  endfunction

  function automatic void make_rand(input bit ones, output logic [63:0] m[16]);
    for (int i = 0; i < 16; i++)
      m[i] = ones ? '1 : {$urandom, $urandom};
  endfunction

  task automatic feed32(input logic [63:0] m[16], input bit gaps);
    logic [63:0] s[80];
    int          n;
    sched(32, m, s);
    for (int i = 0; i < 64; i++) exp32.push_back('{s[i], i});
    for (int i = 0; i < 16; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid32 = 0;
        @(posedge clk); #1;
      end
      in_valid32 = 1;
      in_word32  = m[i][31:0];
      n = 0;
      @(negedge clk);
      while (!in_ready32 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 2000) fail("in32_accept_timeout");
      @(posedge clk); #1;
    end
    in_valid32 = 0;
  endtask

  task automatic feed64(input logic [63:0] m[16], input bit gaps);
    logic [63:0] s[80];
    int          n;
    sched(64, m, s);
    for (int i = 0; i < 80; i++) exp64.push_back('{s[i], i});
    for (int i = 0; i < 16; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid64 = 0;
        @(posedge clk); #1;
      end
      in_valid64 = 1;
      in_word64  = m[i];
      n = 0;
      @(negedge clk);
      while (!in_ready64 && n < 2000) begin
        @(negedge clk);
        n++;
      end
      if (n >= 2000) fail("in64_accept_timeout");
      @(posedge clk); #1;
    end
    in_valid64 = 0;
  endtask

  task automatic drain;
    int n = 0;
    while ((exp32.size() > 0 || exp64.size() > 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) fail("drain_timeout");
    @(posedge clk); #1;
  endtask

  always @(posedge clk) begin
    #1;
    w_ready32 = rnd32 ? 1'($urandom_range(0, 1)) : 1'b1;
    w_ready64 = rnd64 ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  logic        hold32 = 0, hold64 = 0;
  logic [31:0] pw32;
  logic [63:0] pw64;
  logic [6:0]  pi32, pi64;

  // single compare process: scoreboard pops on each handshake
  always @(negedge clk) begin
    ent_t e;
    cyc++;
    if (rst) begin
      hold32 = 0;
      hold64 = 0;
    end else begin
      if (hold32) begin
        chk("w32_hold_valid", 64'(w_valid32), 64'd1);
        chk("w32_hold_word", 64'(w_out32), 64'(pw32));
        chk("w32_hold_idx", 64'(w_idx32), 64'(pi32));
      end
      if (w_valid32 && w_ready32) begin
        if (exp32.size() == 0) fail("w32_unexpected_word");
        else begin
          e = exp32.pop_front();
          chk("w32_word", 64'(w_out32), e.w);
          chk("w32_idx", 64'(w_idx32), 64'(e.idx));
          chk("w32_last", 64'(w_last32), 64'(e.idx == 63));
          xcyc32.push_back(cyc);
        end
      end
      if (w_valid32 && !w_ready32)
        chk("w32_bp_in_ready", 64'(in_ready32), 64'd0);
      if (flush32) chk("w32_flush_in_ready", 64'(in_ready32), 64'd0);
      hold32 = w_valid32 && !w_ready32 && !flush32;
      pw32 = w_out32;
      pi32 = w_idx32;

      if (hold64) begin
        chk("w64_hold_valid", 64'(w_valid64), 64'd1);
        chk("w64_hold_word", w_out64, pw64);
        chk("w64_hold_idx", 64'(w_idx64), 64'(pi64));
      end
      if (w_valid64 && w_ready64) begin
        if (exp64.size() == 0) fail("w64_unexpected_word");
        else begin
          e = exp64.pop_front();
          chk("w64_word", w_out64, e.w);
          chk("w64_idx", 64'(w_idx64), 64'(e.idx));
          chk("w64_last", 64'(w_last64), 64'(e.idx == 79));
          xcyc64.push_back(cyc);
        end
      end
      if (w_valid64 && !w_ready64)
        chk("w64_bp_in_ready", 64'(in_ready64), 64'd0);
      hold64 = w_valid64 && !w_ready64 && !flush64;
      pw64 = w_out64;
      pi64 = w_idx64;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog_timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] m[16];
    logic [63:0] s[80];
    int          n;

    // model pins from hand-worked values
    make_abc(32, m);
    sched(32, m, s);
    chk("model32_w16", s[16], 64'h6162_6380);
    chk("model32_w17", s[17], 64'h000F_0000);
    make_abc(64, m);
    sched(64, m, s);
    chk("model64_w16", s[16], 64'h6162_6380_0000_0000);
    chk("model64_w17", s[17], 64'h0003_0000_0000_00C0);
    make_rand(1, m);
    sched(32, m, s);
    chk("model32_ones_w16", s[16], 64'h203F_FFFC);

    repeat (3) @(negedge clk);
    chk("rst_w_valid32", 64'(w_valid32), 64'd0);
    chk("rst_w_out32", 64'(w_out32), 64'd0);
    chk("rst_w_idx32", 64'(w_idx32), 64'd0);
    chk("rst_w_last32", 64'(w_last32), 64'd0);
    chk("rst_w_valid64", 64'(w_valid64), 64'd0);
    chk("rst_w_out64", w_out64, 64'd0);
    @(posedge clk); #1;
    rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready32", 64'(in_ready32), 64'd1);
    chk("post_rst_in_ready64", 64'(in_ready64), 64'd1);
    @(posedge clk); #1;

    // abc block, full throughput
    xcyc32.delete();
    make_abc(32, m);
    feed32(m, 0);
    drain();
    chk("s1_count", 64'(xcyc32.size()), 64'd64);
    if (xcyc32.size() == 64)
      chk("s1_span", 64'(xcyc32[63] - xcyc32[0]), 64'd63);

    xcyc64.delete();
    make_abc(64, m);
    feed64(m, 0);
    drain();
    chk("s2_count", 64'(xcyc64.size()), 64'd80);
    if (xcyc64.size() == 80)
      chk("s2_span", 64'(xcyc64[79] - xcyc64[0]), 64'd79);

    // random backpressure
    rnd32 = 1;
    make_abc(32, m);
    feed32(m, 0);
    drain();
    rnd32 = 0;

    // back-to-back blocks, no bubble
    xcyc32.delete();
    make_rand(0, m);
    feed32(m, 0);
    make_abc(32, m);
    feed32(m, 0);
    drain();
    chk("s4_count", 64'(xcyc32.size()), 64'd128);
    if (xcyc32.size() == 128)
      chk("s4_span", 64'(xcyc32[127] - xcyc32[0]), 64'd127);

    // flush at idx 30
    make_abc(32, m);
    feed32(m, 0);
    n = 0;
    while (!(w_valid32 && w_idx32 == 7'd30) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) fail("s5_idx30_timeout");
    flush32    = 1;
    in_valid32 = 1;
    in_word32  = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    flush32    = 0;
    in_valid32 = 0;
    chk("s5_flush_w_valid", 64'(w_valid32), 64'd0);
    exp32.delete();
    make_abc(32, m);
    feed32(m, 0);
    drain();

    // async reset mid-EXPAND
    make_abc(32, m);
    feed32(m, 0);
    n = 0;
    while (!(w_valid32 && w_idx32 >= 7'd20) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 500) fail("s6_expand_timeout");
    #3 rst = 1;
    #1 chk("s6_rst_w_valid", 64'(w_valid32), 64'd0);
    exp32.delete();
    #2 rst = 0;
    @(negedge clk);
    chk("s6_in_ready", 64'(in_ready32), 64'd1);
    @(posedge clk); #1;
    make_abc(32, m);
    feed32(m, 0);
    drain();

    // all-ones wrap and random blocks, both widths
    rnd32 = 1;
    rnd64 = 1;
    make_rand(1, m);
    feed32(m, 1);
    feed64(m, 1);
    drain();
    for (int k = 0; k < 3; k++) begin
      make_rand(0, m);
      feed32(m, 1);
      make_rand(0, m);
      feed64(m, k[0]);
      drain();
    end
    rnd32 = 0;
    rnd64 = 0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
